// File: rtl/perf_event_monitor.sv
// Performance event monitor: cycle/retire/branch/event counters with halt-drain FSM.
// Define PERF_SAT_EN to make counters saturate at all-ones instead of wrapping.
module perf_event_monitor #(
    parameter int          CNT_W     = 32,
    parameter int          NUM_EVT   = 4,
    parameter logic [31:0] HALT_INSN = 32'h1111_1111,
    parameter int          DRAIN_CYC = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic                                 i_stop,
    input  logic                                 i_clear,
    input  logic                                 i_insn_vld,
    input  logic                                 i_br,
    input  logic                                 i_redirect,
    input  logic [(NUM_EVT > 0 ? NUM_EVT : 1)-1:0] i_evt,
    input  logic [31:0]                          i_if_instr,
    input  logic [$clog2(5+NUM_EVT)-1:0]         i_rd_sel,
    output logic [CNT_W-1:0]                     o_rd_data,
    output logic [1:0]                           o_state,
    output logic                                 o_done,
    output logic [5+NUM_EVT-1:0]                 o_ovf
);

    localparam int NCNT  = 5 + NUM_EVT;
    localparam int SEL_W = $clog2(NCNT);
    localparam int DW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD =
        (DRAIN_CYC > 0) ? DW'(DRAIN_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   drain;
    logic [DW-1:0]   drain_nxt;
    logic            halt;
    logic            active;
    logic [NCNT-1:0] inc;
    logic [CNT_W-1:0] cnt [NCNT];
    logic [CNT_W-1:0] rd_mux;

    assign halt   = (i_if_instr == HALT_INSN);
    assign active = (state == RUN) || (state == DRAIN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            drain <= '0;
        end else begin
            state <= state_nxt;
            drain <= drain_nxt;
        end
    end

    // Stop outranks start and halt; clear only forces DONE back to IDLE.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain;
        unique case (state)
            IDLE: begin
                if (i_start && !i_stop)
                    state_nxt = RUN;
            end
            RUN: begin
                if (i_stop) begin
                    state_nxt = IDLE;
                end else if (halt) begin
                    if (DRAIN_CYC == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (i_stop)
                    state_nxt = IDLE;
                else if (drain == '0)
                    state_nxt = DONE;
                else
                    drain_nxt = drain - 1'b1;
            end
            DONE: begin
                if (i_clear)
                    state_nxt = IDLE;
                else if (i_start && !i_stop)
                    state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = i_insn_vld;
        inc[2] = i_br;
        inc[3] = i_br & i_redirect;
        inc[4] = i_br & ~i_redirect;
        for (int k = 0; k < NUM_EVT; k++)
            inc[5+k] = i_evt[k];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NCNT; i++)
                cnt[i] <= '0;
            o_ovf <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < NCNT; i++)
                cnt[i] <= '0;
            o_ovf <= '0;
        end else if (active) begin
            for (int i = 0; i < NCNT; i++) begin
                if (inc[i]) begin
                    if (&cnt[i]) begin
                        o_ovf[i] <= 1'b1;
`ifdef PERF_SAT_EN
                        cnt[i] <= cnt[i];
`else
                        cnt[i] <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Unmatched selects fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCNT; i++)
            if (i_rd_sel == SEL_W'(i))
                rd_mux = cnt[i];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_rd_data <= '0;
        else
            o_rd_data <= rd_mux;
    end

    assign o_state = state;
    assign o_done  = (state == DONE);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Scoreboard bench for perf_event_monitor (CNT_W=8, NUM_EVT=2, DRAIN_CYC=4).
module tb_perf_event_monitor;

    localparam int K_DATA  = 0;
    localparam int K_STATE = 1;
    localparam int K_OVF   = 2;
    localparam int K_DONE  = 3;
    localparam logic [31:0] HALT = 32'h1111_1111;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic       insn_vld;
    logic       br;
    logic       redirect;
    logic [1:0] evt;
    logic [31:0] if_instr;
    logic [2:0] rd_sel;
    logic [7:0] rd_data;
    logic [1:0] state;
    logic       done;
    logic [6:0] ovf;

    perf_event_monitor #(
        .CNT_W(8),
        .NUM_EVT(2),
        .HALT_INSN(32'h1111_1111),
        .DRAIN_CYC(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_stop(stop),
        .i_clear(clear),
        .i_insn_vld(insn_vld),
        .i_br(br),
        .i_redirect(redirect),
        .i_evt(evt),
        .i_if_instr(if_instr),
        .i_rd_sel(rd_sel),
        .o_rd_data(rd_data),
        .o_state(state),
        .o_done(done),
        .o_ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int issued  = 0;
    int checked = 0;
    int checks  = 0;
    int errors  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation that is due after the next clock edge.
    task automatic expect_at(input int kind, input logic [2:0] sel,
                             input logic [31:0] exp, input string name);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        q.push_back(it);
        if (kind == K_DATA)
            rd_sel = sel;
        step();
        @(negedge clk);
        issued++;
    endtask

    task automatic check_now(input int kind, input logic [31:0] exp,
                             input string name);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        q.push_back(it);
        issued++;
    endtask

    initial begin : monitor
        item_t       it;
        logic [31:0] act;
        forever begin
            wait (checked != issued);
            it = q.pop_front();
            case (it.kind)
                K_DATA:  act = 32'(rd_data);
                K_STATE: act = 32'(state);
                K_OVF:   act = 32'(ovf);
                default: act = 32'(done);
            endcase
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s actual %0h required %0h",
                         it.name, act, it.exp);
            end
            checked++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] exp_wrap;
        rst = 1'b1; start = 0; stop = 0; clear = 0; insn_vld = 0;
        br = 0; redirect = 0; evt = '0; if_instr = '0; rd_sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        expect_at(K_DATA, 3'd0, 0, "rst_cnt0");
        expect_at(K_STATE, 3'd0, 0, "rst_state");
        expect_at(K_OVF, 3'd0, 0, "rst_ovf");
        expect_at(K_DONE, 3'd0, 0, "rst_done");

        start = 1; step(); start = 0;
        insn_vld = 1;
        repeat (9) step();
        stop = 1; step(); stop = 0;
        insn_vld = 0;
        expect_at(K_DATA, 3'd0, 10, "run_cycles");
        expect_at(K_DATA, 3'd1, 10, "run_insns");
        expect_at(K_STATE, 3'd0, 0, "run_stopped");

        start = 1; step(); start = 0;
        for (int i = 0; i < 6; i++) begin
            br = 1;
            redirect = (i < 2);
            evt = {(i < 2), 1'b1};
            step();
            br = 0; redirect = 0; evt = '0;
            step();
        end
        stop = 1; step(); stop = 0;
        expect_at(K_DATA, 3'd0, 23, "br_cycles");
        expect_at(K_DATA, 3'd1, 10, "br_insns");
        expect_at(K_DATA, 3'd2, 6, "br_count");
        expect_at(K_DATA, 3'd3, 2, "br_miss");
        expect_at(K_DATA, 3'd4, 4, "br_hit");
        expect_at(K_DATA, 3'd5, 6, "evt0");
        expect_at(K_DATA, 3'd6, 2, "evt1");

        start = 1; step(); start = 0;
        if_instr = HALT; step();
        expect_at(K_STATE, 3'd0, 2, "drain1");
        expect_at(K_STATE, 3'd0, 2, "drain2");
        expect_at(K_STATE, 3'd0, 2, "drain3");
        expect_at(K_STATE, 3'd0, 3, "drain_done");
        if_instr = '0;
        expect_at(K_DONE, 3'd0, 1, "done_flag");
        repeat (20) step();
        expect_at(K_DATA, 3'd0, 28, "done_hold");

        start = 1; step(); start = 0;
        repeat (2) step();
        stop = 1; step(); stop = 0;
        expect_at(K_DATA, 3'd0, 31, "resume");
        start = 1; stop = 1;
        expect_at(K_STATE, 3'd0, 0, "stop_over_start");
        start = 0; stop = 0;

        clear = 1; step(); clear = 0;
        start = 1; step(); start = 0;
        repeat (256) step();
        stop = 1; step(); stop = 0;
`ifdef PERF_SAT_EN
        exp_wrap = 255;
`else
        exp_wrap = 1;
`endif
        expect_at(K_DATA, 3'd0, exp_wrap, "ovf_cnt0");
        expect_at(K_OVF, 3'd0, 32'h01, "ovf_flag");
        expect_at(K_DATA, 3'd1, 0, "ovf_insns");

        start = 1; step(); start = 0;
        if_instr = HALT; step(); if_instr = '0;
        repeat (4) step();
        expect_at(K_STATE, 3'd0, 3, "done2");
        clear = 1; insn_vld = 1; step();
        clear = 0; insn_vld = 0;
        expect_at(K_STATE, 3'd0, 0, "clr_state");
        expect_at(K_OVF, 3'd0, 0, "clr_ovf");
        for (int i = 0; i < 7; i++)
            expect_at(K_DATA, 3'(i), 0, $sformatf("clr_cnt%0d", i));
        expect_at(K_DATA, 3'd7, 0, "sel_oob");

        start = 1; step(); start = 0;
        repeat (37) step();
        expect_at(K_DATA, 3'd0, 37, "pre_rst");
        #1 rst = 1;
        #1;
        check_now(K_DATA, 0, "rst_async_rd");
        check_now(K_STATE, 0, "rst_async_state");
        @(negedge clk);
        rst = 0;
        start = 1; step(); start = 0;
        repeat (3) step();
        expect_at(K_DATA, 3'd0, 3, "post_rst_cnt");
        expect_at(K_STATE, 3'd0, 1, "post_rst_run");
        stop = 1; step(); stop = 0;

        for (int i = 0; i < 10 && checked != issued; i++)
            @(negedge clk);
        if (checked != issued) begin
            errors++;
            $display("FAIL drain actual %0d required %0d", checked, issued);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
